// File: rtl/fifo_drain_packer_if.sv
// fifo_drain_packer_if: FIFO read side plus packed output stream.
//   master: the packer (drives fifo_read and the out_* word, samples the rest)
//   slave : the environment (FIFO model / downstream sink)
interface fifo_drain_packer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int PACK       = 2
);
  logic                       fifo_empty;
  logic [DATA_WIDTH-1:0]      fifo_dout;
  logic                       fifo_read;
  logic [PACK*DATA_WIDTH-1:0] out_data;
  logic [PACK-1:0]            out_keep;
  logic                       out_valid;
  logic                       out_ready;

  modport master (
    input  fifo_empty, fifo_dout, out_ready,
    output fifo_read, out_data, out_keep, out_valid
  );

  modport slave (
    output fifo_empty, fifo_dout, out_ready,
    input  fifo_read, out_data, out_keep, out_valid
  );
endinterface

// File: rtl/fifo_drain_packer.sv
// fifo_drain_packer: pops bytes from a FIFO, packs PACK of them per word and
// presents words through a one-entry valid/ready output register. A flush
// pulse emits any partial word with a lane-keep mask.
// Ports:
//   clk, reset      - clock, synchronous active-high reset
//   enable          - allows new FIFO reads
//   flush           - request to drain a partial word
//   flush_done      - one-cycle pulse when the flush completes
//   word_count      - accepted words (full or partial), wraps at 16 bits
//   bus (master)    - fifo_empty/fifo_dout/fifo_read, out_data/keep/valid/ready

// One assembly lane: captures a FIFO byte and offers a keep-masked copy.
module fifo_drain_packer_lane #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic          keep,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] q,
  output logic [DW-1:0] qm
);
  always_ff @(posedge clk) begin
    if (reset)   q <= '0;
    else if (we) q <= din;
  end

  assign qm = keep ? q : '0;
endmodule

module fifo_drain_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int PACK       = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                flush,
  output logic                flush_done,
  output logic [15:0]         word_count,
  fifo_drain_packer_if.master bus
);
  localparam int             FW     = $clog2(PACK + 1);
  localparam logic [FW-1:0]  PACK_F = FW'(PACK);
  localparam logic [FW:0]    PACK_U = (FW + 1)'(PACK);

  typedef enum logic {RUN, DRAIN} state_t;

  state_t                            state_q, state_d;
  logic [FW-1:0]                     fill_q, fill_d, eff_fill;
  logic                              inflight_q;
  logic [FW:0]                       used;
  logic                              slot_free, full, xfer, part_ld, rd;
  logic [PACK-1:0]                   lane_we, part_keep;
  logic [PACK-1:0][DATA_WIDTH-1:0]   lane_q, lane_msk;
  logic [PACK*DATA_WIDTH-1:0]        od_q;
  logic [PACK-1:0]                   keep_q;
  logic                              ov_q;
  logic [15:0]                       wc_q;

  assign slot_free = !ov_q || bus.out_ready;
  assign full      = (fill_q == PACK_F);
  assign xfer      = full && slot_free;
  // A transfer empties the assembly register this cycle, so captures and
  // read reservations already see it as empty.
  assign eff_fill  = xfer ? '0 : fill_q;
  // Lanes already held plus the one reserved by a read still in flight.
  assign used      = {1'b0, eff_fill} + {{FW{1'b0}}, inflight_q};
  assign rd        = !reset && (state_q == RUN) && enable && !flush &&
                     !bus.fifo_empty && (used < PACK_U);

  for (genvar g = 0; g < PACK; g++) begin : g_lane
    assign lane_we[g]   = inflight_q && (eff_fill == FW'(g));
    assign part_keep[g] = (FW'(g) < fill_q);
    fifo_drain_packer_lane #(.DW(DATA_WIDTH)) u_lane (
      .clk  (clk),
      .reset(reset),
      .we   (lane_we[g]),
      .keep (part_keep[g]),
      .din  (bus.fifo_dout),
      .q    (lane_q[g]),
      .qm   (lane_msk[g])
    );
  end

  // DRAIN waits for the in-flight byte and any pending full transfer before
  // deciding between an empty completion and a partial word.
  always_comb begin
    state_d    = state_q;
    part_ld    = 1'b0;
    flush_done = 1'b0;
    case (state_q)
      RUN:   if (flush) state_d = DRAIN;
      DRAIN: if (!inflight_q && !full) begin
        if (fill_q == '0) begin
          flush_done = 1'b1;
          state_d    = RUN;
        end else if (slot_free) begin
          part_ld    = 1'b1;
          flush_done = 1'b1;
          state_d    = RUN;
        end
      end
    endcase
  end

  always_comb begin
    fill_d = eff_fill;
    if (inflight_q) fill_d = eff_fill + FW'(1);
    if (part_ld)    fill_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RUN;
      fill_q     <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fill_q     <= fill_d;
      inflight_q <= rd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      od_q   <= '0;
      keep_q <= '0;
      ov_q   <= 1'b0;
      wc_q   <= '0;
    end else begin
      if (ov_q && bus.out_ready) wc_q <= wc_q + 16'd1;
      if (xfer) begin
        od_q   <= lane_q;
        keep_q <= '1;
        ov_q   <= 1'b1;
      end else if (part_ld) begin
        od_q   <= lane_msk;
        keep_q <= part_keep;
        ov_q   <= 1'b1;
      end else if (bus.out_ready) begin
        ov_q   <= 1'b0;
      end
    end
  end

  assign bus.fifo_read = rd;
  assign bus.out_data  = od_q;
  assign bus.out_keep  = keep_q;
  assign bus.out_valid = ov_q;
  assign word_count    = wc_q;
endmodule
